// File: rtl/divider_pkg.sv
// Shared types and helpers for the multi-channel strobe divider.
package divider_pkg;

  localparam int DIV_W_DEFAULT = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A ratio of zero has no meaningful period, so it behaves as ratio one.
  function automatic logic [31:0] sanitize_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/divider_channel.sv
// One strobe channel: period counter, active/shadow ratio pair, strobe flop.
// Optional o_square output is built only when DIVIDER_SQUARE_EN is defined.
module divider_channel #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 240
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_val,
  output logic             o_strobe
`ifdef DIVIDER_SQUARE_EN
  ,
  output logic             o_square
`endif
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] active_div;
  logic [DIV_W-1:0] shadow_div;
  logic             wrap;
  logic [DIV_W-1:0] next_div;

  assign wrap     = (count == active_div - DIV_W'(1));
  // A write landing on the boundary cycle wins over the older shadow value.
  assign next_div = i_wr ? i_val : shadow_div;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count      <= '0;
      active_div <= DIV_W'(DEFAULT_DIV);
      shadow_div <= DIV_W'(DEFAULT_DIV);
      o_strobe   <= 1'b0;
    end else begin
      if (i_wr) shadow_div <= i_val;
      if (!i_run) begin
        count    <= '0;
        o_strobe <= 1'b0;
        if (i_wr) active_div <= i_val;
      end else if (i_sync) begin
        count      <= '0;
        o_strobe   <= 1'b0;
        active_div <= next_div;
      end else if (wrap) begin
        count      <= '0;
        o_strobe   <= 1'b1;
        active_div <= next_div;
      end else begin
        count    <= count + DIV_W'(1);
        o_strobe <= 1'b0;
      end
    end
  end

`ifdef DIVIDER_SQUARE_EN
  // Registered from the current count so the rising edge follows the strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) o_square <= 1'b0;
    else         o_square <= i_run && (count < (active_div >> 1));
  end
`endif

endmodule

// File: rtl/divider_strobe_multi.sv
// N_CH-channel programmable strobe divider: arm FSM, ratio write decode, sync fan-out.
// Define DIVIDER_SQUARE_EN to add the per-channel o_square output.
module divider_strobe_multi
  import divider_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 240,
  parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ready,
  input  logic             i_sync,
  input  logic             i_div_wr,
  input  logic [CH_W-1:0]  i_div_ch,
  input  logic [DIV_W-1:0] i_div_val,
  output logic             o_armed,
  output logic [N_CH-1:0]  o_strobe
`ifdef DIVIDER_SQUARE_EN
  ,
  output logic [N_CH-1:0]  o_square
`endif
);

  state_t           state;
  logic             run;
  logic [DIV_W-1:0] div_val_s;

  always_ff @(posedge i_clk) begin
    if (i_reset)                            state <= ST_IDLE;
    else if (state == ST_IDLE && i_ready)   state <= ST_RUN;
  end

  assign run       = (state == ST_RUN);
  assign o_armed   = run;
  assign div_val_s = DIV_W'(sanitize_div(32'(i_div_val)));

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    // Only in-range channel numbers can match, so out-of-range writes are dropped.
    logic wr_sel;
    assign wr_sel = i_div_wr && (32'(i_div_ch) == c);

    divider_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_run    (run),
      .i_sync   (i_sync),
      .i_wr     (wr_sel),
      .i_val    (div_val_s),
      .o_strobe (o_strobe[c])
`ifdef DIVIDER_SQUARE_EN
      ,
      .o_square (o_square[c])
`endif
    );
  end

endmodule

// File: tb/tb_divider_strobe_multi.sv
// Directed bench for divider_strobe_multi (4-channel main instance, 3-channel instance for range checks).
module tb_divider_strobe_multi;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_ready = 1'b0;
  logic        i_sync = 1'b0;
  logic        i_div_wr = 1'b0;
  logic [1:0]  i_div_ch = '0;
  logic [15:0] i_div_val = '0;
  logic        o_armed;
  logic [3:0]  o_strobe;

  logic        wr3 = 1'b0;
  logic [1:0]  ch3 = '0;
  logic [15:0] val3 = '0;
  logic        armed3;
  logic [2:0]  strobe3;

`ifdef DIVIDER_SQUARE_EN
  logic [3:0]  o_square;
  logic [2:0]  square3;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;
  int es = 0;
  int at = 0;

  always #5 i_clk = ~i_clk;

  divider_strobe_multi u_dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_ready   (i_ready),
    .i_sync    (i_sync),
    .i_div_wr  (i_div_wr),
    .i_div_ch  (i_div_ch),
    .i_div_val (i_div_val),
    .o_armed   (o_armed),
    .o_strobe  (o_strobe)
`ifdef DIVIDER_SQUARE_EN
    ,
    .o_square  (o_square)
`endif
  );

  divider_strobe_multi #(.N_CH(3), .DEFAULT_DIV(4)) u_dut3 (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_ready   (i_ready),
    .i_sync    (i_sync),
    .i_div_wr  (wr3),
    .i_div_ch  (ch3),
    .i_div_val (val3),
    .o_armed   (armed3),
    .o_strobe  (strobe3)
`ifdef DIVIDER_SQUARE_EN
    ,
    .o_square  (square3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic arm();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    e0 = cyc;
  endtask

  task automatic write_div(input logic [1:0] ch, input logic [15:0] val);
    i_div_wr  = 1'b1;
    i_div_ch  = ch;
    i_div_val = val;
    tick();
    i_div_wr  = 1'b0;
  endtask

  task automatic wait_strobe(input int ch, input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_strobe[ch]) begin
        when = cyc;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_vec;

    // Default ratio on all channels
    do_reset();
    chk("reset_armed", 32'(o_armed), 0);
    chk("reset_strobe", 32'(o_strobe), 0);
    arm();
    chk("armed_after_ready", 32'(o_armed), 1);
    wait_strobe(0, 300, at);
    chk("def_first_240", at - e0, 240);
    chk("def_all_coincide", 32'(o_strobe), 32'hF);
    wait_strobe(0, 300, at);
    chk("def_second_480", at - e0, 480);
    wait_strobe(0, 300, at);
    chk("def_third_720", at - e0, 720);

    // Idle writes: ch1=5, ch2=0 (treated as 1)
    do_reset();
    write_div(2'd1, 16'd5);
    write_div(2'd2, 16'd0);
    chk("idle_not_armed", 32'(o_armed), 0);
    arm();
    chk("idle_wr_no_strobe_at_arm", 32'(o_strobe), 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_vec = {1'b0, 1'b1, (k % 5 == 0), 1'b0};
      chk($sformatf("idle_wr_vec_k%0d", k), 32'(o_strobe), 32'(exp_vec));
`ifdef DIVIDER_SQUARE_EN
      chk($sformatf("square_ch1_k%0d", k), 32'(o_square[1]), 32'(((k - 1) % 5) < 2));
      chk($sformatf("square_ch2_k%0d", k), 32'(o_square[2]), 0);
`endif
    end
    wait_strobe(0, 300, at);
    chk("idle_wr_ch0_240", at - e0, 240);

    // Run-time writes: 10 -> (4, then 6) before the wrap
    do_reset();
    write_div(2'd1, 16'd10);
    arm();
    while (cyc < e0 + 3) tick();
    write_div(2'd1, 16'd4);
    tick();
    write_div(2'd1, 16'd6);
    wait_strobe(1, 50, at);
    chk("run_wr_period_kept_10", at - e0, 10);
    wait_strobe(1, 50, at);
    chk("run_wr_last_wins_16", at - e0, 16);
    wait_strobe(1, 50, at);
    chk("run_wr_last_wins_22", at - e0, 22);

    // Write ch0=7 on its wrap cycle
    while (cyc < e0 + 239) tick();
    write_div(2'd0, 16'd7);
    chk("wrap_wr_strobe_240", 32'(o_strobe[0]), 1);
    wait_strobe(0, 50, at);
    chk("wrap_wr_next_247", at - e0, 247);
    wait_strobe(0, 50, at);
    chk("wrap_wr_next_254", at - e0, 254);

    // Sync coinciding with the wrap
    do_reset();
    arm();
    while (cyc < e0 + 239) tick();
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    es = cyc;
    chk("sync_suppresses_strobe", 32'(o_strobe), 0);
    wait_strobe(0, 300, at);
    chk("sync_next_240", at - es, 240);
    chk("sync_realigned", 32'(o_strobe), 32'hF);

    // Reset mid-period after a shadow write; reset beats i_ready
    tick();
    write_div(2'd3, 16'd9);
    tick();
    tick();
    i_reset = 1'b1;
    i_ready = 1'b1;
    tick();
    chk("midreset_armed", 32'(o_armed), 0);
    chk("midreset_strobe", 32'(o_strobe), 0);
    i_reset = 1'b0;
    i_ready = 1'b0;
    tick();
    chk("after_reset_idle", 32'(o_armed), 0);

    // Out-of-range channel on the 3-channel instance
    wr3  = 1'b1;
    ch3  = 2'd3;
    val3 = 16'd1;
    tick();
    wr3  = 1'b0;
    arm();
    while (cyc < e0 + 3) tick();
    chk("oor_no_early_strobe", 32'(strobe3), 0);
    tick();
    chk("oor_default_4", 32'(strobe3), 32'h7);

    wait_strobe(3, 300, at);
    chk("rearm_ch3_240", at - e0, 240);
    chk("rearm_all_coincide", 32'(o_strobe), 32'hF);
    wait_strobe(3, 300, at);
    chk("rearm_ch3_480", at - e0, 480);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
